set_assoc_cache: RTL

- Two-way set-associative, write-back, write-allocate data cache with one word per line.
- Sits between the CPU load/store stage and main memory.
- Generalises the direct-mapped cache: parametrised width and set count, dirty tracking, LRU replacement, a memory handshake and a miss-handling state machine that stalls the pipeline.

---
 rtl/cache_pkg.sv | 23 ++
 rtl/cache_way.sv | 51 +++++
 rtl/set_assoc_cache.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared types and defaults for the two-way set-associative data cache.
package cache_pkg;
   localparam int CL_DATA_W     = 32;
   localparam int CL_ADDR_W     = 32;
   localparam int CL_SETS       = 8;
   localparam int CL_INDEX_BITS = $clog2(CL_SETS);
   localparam int CL_TAG_BITS   = CL_ADDR_W - CL_INDEX_BITS - 2;
   localparam int WAYS          = 2;

   // One cache line at the default geometry.
   typedef struct packed {
      logic                   valid;
      logic                   dirty;
      logic [CL_TAG_BITS-1:0] tag;
      logic [CL_DATA_W-1:0]   data;
   } cache_line_t;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      REFILL    = 2'd2
   } cache_state_t;
endpackage

// File: rtl/cache_way.sv
// One way of the cache: line array with a combinational read port and a
// single synchronous write port. Only valid/dirty are reset.
module cache_way #(
   parameter  int DATA_WIDTH = 32,
   parameter  int TAG_BITS   = 27,
   parameter  int SETS       = 8,
   localparam int INDEX_BITS = $clog2(SETS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [INDEX_BITS-1:0] i_rd_idx,
   output logic                  o_valid,
   output logic                  o_dirty,
   output logic [TAG_BITS-1:0]   o_tag,
   output logic [DATA_WIDTH-1:0] o_data,
   input  logic                  i_we,
   input  logic [INDEX_BITS-1:0] i_wr_idx,
   input  logic                  i_valid,
   input  logic                  i_dirty,
   input  logic [TAG_BITS-1:0]   i_tag,
   input  logic [DATA_WIDTH-1:0] i_data
);
   logic [SETS-1:0]       r_valid;
   logic [SETS-1:0]       r_dirty;
   logic [TAG_BITS-1:0]   r_tag  [SETS];
   logic [DATA_WIDTH-1:0] r_data [SETS];

   assign o_valid = r_valid[i_rd_idx];
   assign o_dirty = r_dirty[i_rd_idx];
   assign o_tag   = r_tag[i_rd_idx];
   assign o_data  = r_data[i_rd_idx];

   // status bits: cleared on reset, written with the line
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= '0;
         r_dirty <= '0;
      end else if (i_we) begin
         r_valid[i_wr_idx] <= i_valid;
         r_dirty[i_wr_idx] <= i_dirty;
      end
   end

   // payload: meaningless until valid is set, so no reset
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_tag[i_wr_idx]  <= i_tag;
         r_data[i_wr_idx] <= i_data;
      end
   end
endmodule

// File: rtl/set_assoc_cache.sv
// Two-way set-associative write-back/write-allocate cache, one word per line.
// Misses stall the CPU while the FSM writes back a dirty victim and refills.
module set_assoc_cache
   import cache_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int SETS       = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   output logic                  cpu_stall,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ready
);
   localparam int INDEX_BITS = $clog2(SETS);
   localparam int TAG_BITS   = ADDR_WIDTH - INDEX_BITS - 2;

   logic [INDEX_BITS-1:0]            w_idx;
   logic [TAG_BITS-1:0]              w_tag_in;
   logic                             w_unused;
   logic [WAYS-1:0]                  w_valid, w_dirty, w_hit_vec, w_we;
   logic [WAYS-1:0][TAG_BITS-1:0]    w_tag;
   logic [WAYS-1:0][DATA_WIDTH-1:0]  w_data;
   logic                             w_hit, w_hit_way, w_victim;
   logic                             w_wr_dirty;
   logic [DATA_WIDTH-1:0]            w_wr_data;

   cache_state_t                     r_state;
   logic [SETS-1:0]                  r_lru;
   logic                             r_victim;
   logic                             r_mem_req, r_mem_we;
   logic [ADDR_WIDTH-1:0]            r_mem_addr;
   logic [DATA_WIDTH-1:0]            r_mem_wdata;

   assign w_idx     = cpu_addr[INDEX_BITS+1:2];
   assign w_tag_in  = cpu_addr[ADDR_WIDTH-1:INDEX_BITS+2];
   assign w_unused  = ^cpu_addr[1:0];

   for (genvar g = 0; g < WAYS; g++) begin : g_way
      cache_way #(.DATA_WIDTH(DATA_WIDTH), .TAG_BITS(TAG_BITS), .SETS(SETS)) u_way (
         .clk      (clk),
         .rst      (rst),
         .i_rd_idx (w_idx),
         .o_valid  (w_valid[g]),
         .o_dirty  (w_dirty[g]),
         .o_tag    (w_tag[g]),
         .o_data   (w_data[g]),
         .i_we     (w_we[g]),
         .i_wr_idx (w_idx),
         .i_valid  (1'b1),
         .i_dirty  (w_wr_dirty),
         .i_tag    (w_tag_in),
         .i_data   (w_wr_data)
      );
      assign w_hit_vec[g] = w_valid[g] & (w_tag[g] == w_tag_in);
   end

   assign w_hit     = |w_hit_vec;
   assign w_hit_way = w_hit_vec[1];
   assign cpu_stall = (r_state != IDLE) | (cpu_req & ~w_hit);

   assign mem_req   = r_mem_req;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;

   // hit data mux; zero when nothing matches
   always_comb begin
      cpu_rdata = '0;
      for (int w = 0; w < WAYS; w++)
         if (w_hit_vec[w]) cpu_rdata = w_data[w];
   end

   // victim: first invalid way, else the set's LRU way
   always_comb begin
      if (!w_valid[0])      w_victim = 1'b0;
      else if (!w_valid[1]) w_victim = 1'b1;
      else                  w_victim = r_lru[w_idx];
   end

   // array write port: refill completion or store hit, never both; reset blocks writes
   always_comb begin
      w_we       = '0;
      w_wr_dirty = 1'b0;
      w_wr_data  = mem_rdata;
      if (!rst) begin
         if (r_state == REFILL && mem_ready) begin
            w_we[r_victim] = 1'b1;
         end else if (r_state == IDLE && cpu_req && w_hit && cpu_we) begin
            w_we[w_hit_way] = 1'b1;
            w_wr_dirty      = 1'b1;
            w_wr_data       = cpu_wdata;
         end
      end
   end

   // miss-handling FSM with registered memory-side outputs and LRU update
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_lru       <= '0;
         r_victim    <= 1'b0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         case (r_state)
            IDLE: if (cpu_req) begin
               if (w_hit) begin
                  r_lru[w_idx] <= ~w_hit_way;
               end else begin
                  r_victim  <= w_victim;
                  r_mem_req <= 1'b1;
                  if (w_valid[w_victim] && w_dirty[w_victim]) begin
                     r_state     <= WRITEBACK;
                     r_mem_we    <= 1'b1;
                     r_mem_addr  <= {w_tag[w_victim], w_idx, 2'b00};
                     r_mem_wdata <= w_data[w_victim];
                  end else begin
                     r_state     <= REFILL;
                     r_mem_we    <= 1'b0;
                     r_mem_addr  <= {w_tag_in, w_idx, 2'b00};
                     r_mem_wdata <= '0;
                  end
               end
            end
            WRITEBACK: if (mem_ready) begin
               r_state     <= REFILL;
               r_mem_we    <= 1'b0;
               r_mem_addr  <= {w_tag_in, w_idx, 2'b00};
               r_mem_wdata <= '0;
            end
            REFILL: if (mem_ready) begin
               r_lru[w_idx] <= ~r_victim;
               r_state      <= IDLE;
               r_mem_req    <= 1'b0;
               r_mem_addr   <= '0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule
